// File: rtl/instruction_fetch_stage_pkg.sv
// instruction_fetch_stage_pkg: shared CPU definitions (NOP, default vectors, FSM encoding, IF/ID record).
package instruction_fetch_stage_pkg;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0004;

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR, valid: 1'b0};
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// instruction_fetch_stage_if: instruction-memory fetch bus (address out, instruction word back).
interface instruction_fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    modport master (output imem_addr, input imem_instr);
    modport slave (input imem_addr, output imem_instr);
endinterface

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// if_id_reg: inter-stage pipeline register; bubble beats load, neither means hold.
module if_id_reg
    import instruction_fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   bubble,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            q <= IF_ID_BUBBLE;
        else if (bubble)
            q <= IF_ID_BUBBLE;
        else if (load)
            q <= d;
    end
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS IF stage - PC register, redirects, stalls, flushes, IF/ID capture.
// Optional IFETCH_MISALIGN_TRAP_EN traps misaligned redirects to EXC_VECTOR instead of truncating them.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic                       clk,
    input  logic                       reset_n,
    instruction_fetch_stage_if.master  imem,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_target,
    output logic [31:0]                if_id_pc,
    output logic [31:0]                if_id_pc_plus4,
    output logic [31:0]                if_id_instr,
    output logic                       if_id_valid,
    output logic                       fetch_exc
);
    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next, pc_plus4, redirect_pc;
    logic         bubble, load, trap;
    if_id_t       if_id_d, if_id_q;

    assign pc_plus4       = pc + 32'd4;
    assign imem.imem_addr = pc;

`ifdef IFETCH_MISALIGN_TRAP_EN
    assign trap        = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign redirect_pc = trap ? EXC_VECTOR : redirect_target;
`else
    assign trap        = 1'b0;
    assign redirect_pc = {redirect_target[31:2], 2'b00};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // BOOT ignores every input and only injects the initial bubble.
    always_comb begin
        state_next = RUN;
        pc_next    = pc;
        bubble     = 1'b1;
        load       = 1'b0;
        if (state == RUN) begin
            bubble  = redirect_valid || flush;
            load    = !redirect_valid && !stall;
            pc_next = redirect_valid ? redirect_pc : (stall ? pc : pc_plus4);
        end
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fetch_exc <= 1'b0;
        else
            fetch_exc <= (state == RUN) && trap;
    end
`else
    assign fetch_exc = trap;
`endif

    assign if_id_d = '{pc: pc, pc_plus4: pc_plus4, instr: imem.imem_instr, valid: 1'b1};

    if_id_reg u_if_id (
        .clk     (clk),
        .reset_n (reset_n),
        .bubble  (bubble),
        .load    (load),
        .d       (if_id_d),
        .q       (if_id_q)
    );

    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign if_id_instr    = if_id_q.instr;
    assign if_id_valid    = if_id_q.valid;
endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline. Owns the PC register and drives the combinational instruction-memory address.
- Captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Handles hazard-unit stalls, ID-stage flushes and branch/jump/jr redirects, with a one-cycle boot bubble after reset.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- EXC_VECTOR, 32'h80000004, target taken on a misaligned redirect (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- imem_addr  output  32  fetch address; combinational copy of the PC register
- imem_instr  input  32  instruction word returned combinationally by instruction memory for imem_addr
- stall  input  1  hold PC and IF/ID (load-use hazard)
- flush  input  1  squash the IF/ID contents into a bubble
- redirect_valid  input  1  taken branch/jump/jr resolved in ID
- redirect_target  input  32  next PC when redirect_valid=1
- if_id_pc  output  32  PC of the captured instruction
- if_id_pc_plus4  output  32  captured PC+4 (jal link value)
- if_id_instr  output  32  captured instruction
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- fetch_exc  output  1  misaligned-redirect trap pulse

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous, active low; the design is fully synchronous after deassertion.
- Reset values: pc=RESET_PC; state=BOOT; if_id_pc=0; if_id_pc_plus4=0; if_id_instr=32'h00000000 (NOP); if_id_valid=0; fetch_exc=0.
- FSM states: BOOT and RUN.
  - BOOT to RUN on the first rising edge after reset release.
  - During that edge: pc holds, IF/ID is loaded with a bubble, all inputs are ignored.
  - RUN has no exit except reset.
- PC update in RUN, in priority order:
  - redirect_valid: pc <= redirect_target.
  - else stall: pc holds.
  - else pc <= pc + 4, 32-bit wrap modulo 2^32 (32'hFFFFFFFC wraps to 32'h00000000).
- IF/ID update in RUN, in priority order:
  - redirect_valid or flush: bubble (instr=0, valid=0, pc=0, pc_plus4=0).
  - else stall: hold all fields.
  - else load {pc, pc+4, imem_instr, valid=1}.
- Simultaneous events:
  - redirect_valid+stall: the redirect wins on both PC and IF/ID.
  - flush+stall: bubble is written and pc holds.
  - flush alone: pc still advances.
- Latency: an instruction at address A appears on if_id_* one edge after the PC equals A. No branch delay slot; the wrong-path fetch is squashed by the redirect.
- imem_addr always equals pc, including in BOOT.
- Reset mid-operation: all registers return immediately to their reset values and state returns to BOOT.

Optional Feature:
- Macro: IFETCH_MISALIGN_TRAP_EN.
- Defined, and redirect_valid=1 with redirect_target[1:0]!=0:
  - pc <= EXC_VECTOR and IF/ID gets a bubble.
  - fetch_exc=1 for exactly one cycle, registered, asserted the cycle pc becomes EXC_VECTOR.
- Not defined: the redirect target has bits[1:0] forced to 00 on load, and fetch_exc is tied to 0.

Decomposition:
- Shared package/include (cpu_defs): NOP_INSTR=32'h0, default RESET_PC, default EXC_VECTOR, FSM state encodings (BOOT=1'b0, RUN=1'b1).
- One natural sub-module: if_id_reg. It is the pipeline register with load/hold/bubble control, reused for the other inter-stage registers.

Test Plan:
1. Release reset, imem preloaded (addr 0 = 32'h20040003):
   - Edge 1: valid=0, imem_addr=0.
   - Edge 2: if_id_instr=32'h20040003, if_id_pc=0, if_id_pc_plus4=4, valid=1, imem_addr=4.
2. Stall held for 2 cycles with pc=0x8:
   - imem_addr stays 0x8 and if_id_* are unchanged.
   - After release: IF/ID captures pc=0x8 and pc becomes 0xC.
3. Redirect to 0x0C with pc=0x8:
   - Next cycle imem_addr=0xC, valid=0, if_id_instr=0.
   - Following edge: if_id_pc=0xC, valid=1.
4. Simultaneous checks:
   - redirect_valid+stall, target 0x40: pc=0x40 and bubble.
   - flush alone at pc=0x10: pc=0x14 and bubble.
5. Async reset_n pulse mid-run at pc=0x28, asserted between edges: pc, imem_addr and valid go to 0 immediately; BOOT bubble repeats after release.
6. Misaligned redirect target 0x0E:
   - With IFETCH_MISALIGN_TRAP_EN: pc=0x80000004, fetch_exc high for one cycle, bubble.
   - Without: pc=0xC, fetch_exc=0.
